// File: rtl/imm_decode_pkg.sv
// Shared types for the decode-stage immediate sequencer.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    IT_R  = 3'd0,
    IT_I  = 3'd1,
    IT_IL = 3'd2,
    IT_IJ = 3'd3,
    IT_S  = 3'd4,
    IT_B  = 3'd5,
    IT_U  = 3'd6,
    IT_J  = 3'd7
  } instr_type_t;

endpackage

// File: rtl/imm_decode_stage.sv
// Decode-stage immediate sequencer: classifies RV32I words, assembles and
// sign-extends the immediate, and presents results through a 2-entry buffer
// whose outputs come straight from registers.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int unsigned wd_regs_p = 32,
  parameter int unsigned wd_pc_p   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  input  logic [wd_pc_p-1:0]   i_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output instr_type_t          o_instr_type,
  output logic [wd_regs_p-1:0] o_imm,
  output logic [wd_pc_p-1:0]   o_pc,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic                 o_illegal
);

  typedef struct packed {
    instr_type_t          itype;
    logic                 illegal;
    logic [wd_regs_p-1:0] imm;
    logic [wd_pc_p-1:0]   pc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
  } entry_t;

  entry_t      r_mem [2];
  entry_t      r_out;
  logic [0:0]  r_head;
  logic [0:0]  r_tail;
  logic [1:0]  r_count;
  logic        r_valid;
  logic        r_ready;

  instr_type_t w_type;
  logic        w_illegal;
  logic        w_sign;
  logic [31:0] w_imm32;
  entry_t      w_in;
  logic        w_push;
  logic        w_pop;
  logic [0:0]  w_head_nxt;
  logic [0:0]  w_tail_nxt;
  logic [1:0]  w_count_nxt;
  entry_t      w_head_entry;

  // Opcode classification; unknown opcodes fall back to R and flag illegal.
  always_comb begin
    w_type    = IT_R;
    w_illegal = 1'b0;
    case (i_instr[6:0])
      7'b0010011: w_type = IT_I;
      7'b0000011: w_type = IT_IL;
      7'b1100111: w_type = IT_IJ;
      7'b0100011: w_type = IT_S;
      7'b1100011: w_type = IT_B;
      7'b0110111,
      7'b0010111: w_type = IT_U;
      7'b1101111: w_type = IT_J;
      7'b0110011: w_type = IT_R;
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_sign = i_instr[31];

  // Gather the scattered immediate bits into a 32-bit sign-extended value.
  always_comb begin
    w_imm32 = '0;
    case (w_type)
      IT_I, IT_IL, IT_IJ: w_imm32 = {{20{w_sign}}, i_instr[31:20]};
      IT_S: w_imm32 = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      IT_B: w_imm32 = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
      IT_U: w_imm32 = {i_instr[31:12], 12'b0};
      IT_J: w_imm32 = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Pack the decoded input-side entry.
  always_comb begin
    w_in         = '0;
    w_in.itype   = w_type;
    w_in.illegal = w_illegal;
    w_in.imm     = wd_regs_p'($signed(w_imm32));
    w_in.pc      = i_pc;
    w_in.rd      = i_instr[11:7];
    w_in.rs1     = i_instr[19:15];
    w_in.rs2     = i_instr[24:20];
  end

  assign w_push = i_valid & r_ready & ~i_flush;
  assign w_pop  = r_valid & i_ready;

  // Next pointer/occupancy state and the entry that will sit at the head.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_head_nxt  = 1'b0;
      w_tail_nxt  = 1'b0;
      w_count_nxt = 2'd0;
    end else begin
      if (w_push) w_tail_nxt = ~r_tail;
      if (w_pop)  w_head_nxt = ~r_head;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
    // An entry written this cycle into the next head slot bypasses storage.
    w_head_entry = (w_push && (r_tail == w_head_nxt)) ? w_in : r_mem[w_head_nxt];
  end

  // Buffer storage; unreset since it is only read when occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= w_in;
  end

  // Control state and output holding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_out   <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
      r_ready <= (w_count_nxt != 2'd2);
      if (w_count_nxt != 2'd0) r_out <= w_head_entry;
    end
  end

  assign o_valid      = r_valid;
  assign o_ready      = r_ready;
  assign o_instr_type = r_out.itype;
  assign o_illegal    = r_out.illegal;
  assign o_imm        = r_out.imm;
  assign o_pc         = r_out.pc;
  assign o_rd         = r_out.rd;
  assign o_rs1        = r_out.rs1;
  assign o_rs2        = r_out.rs2;

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-stage immediate sequencer for the arriskv core.
- Accepts fetched instruction words over a valid/ready handshake and classifies each by opcode into instr_type_t.
- Assembles the scattered RISC-V immediate fields and sign-extends them to wd_regs_p.
- Presents the result through a registered 2-entry output buffer, so fetch and execute are decoupled and flushable.

Parameters:
wd_regs_p, 32, datapath/register width; immediate output width; must be >= 32.
wd_pc_p, 32, width of the program-counter sideband carried with each instruction.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  reset; synchronous, active-high.
i_flush  input  1  discard all buffered entries and any input offered this cycle.
i_valid  input  1  instruction word and PC valid.
o_ready  output  1  stage can accept an entry this cycle.
i_instr  input  32  RV32I instruction word.
i_pc  input  wd_pc_p  PC of i_instr.
o_valid  output  1  head entry valid.
i_ready  input  1  downstream accepts head entry.
o_instr_type  output  instr_type_t  class of head entry.
o_imm  output  wd_regs_p  sign-extended immediate of head entry.
o_pc  output  wd_pc_p  PC of head entry.
o_rd, o_rs1, o_rs2  output  5 each  register fields instr[11:7], [19:15], [24:20].
o_illegal  output  1  head entry opcode unrecognised.

Behaviour:
- Classification on opcode instr[6:0]:
  - 0010011→I; 0000011→IL; 1100111→IJ; 0100011→S; 1100011→B.
  - 0110111 and 0010111→U; 1101111→J; 0110011→R.
  - Any other opcode→R with illegal=1.
- Immediate assembly; s = instr[31] replicated to wd_regs_p:
  - I/IL/IJ: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {s, instr[31:12], 12'b0}.
  - J: {s, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R/illegal: 0.
- Decode/extension is computed combinationally on the input side and written into the buffer. Outputs are driven only from registers, with no combinational path from i_instr to outputs.
- Buffer: 2 entries, with head pointer, tail pointer and a 2-bit count (0..2).
  - Pointers wrap 1→0.
  - Handshake rules:
    - Push when i_valid & o_ready & !i_flush.
    - Pop when o_valid & i_ready.
    - o_ready = (count != 2), registered from count.
    - o_valid = (count != 0).
  - Latency: an entry accepted in cycle N is visible on outputs in cycle N+1.
  - Simultaneous push and pop:
    - count is unchanged.
    - Allowed at count=2: no push, since o_ready=0.
    - At count=0 there is no pop, since o_valid=0.
    - At count=1 the new entry becomes head in the following cycle.
  - Output payload is stable while o_valid & !i_ready; the head entry is never overwritten.
- i_flush:
  - Next cycle count=0 and o_valid=0; pointers reset to 0.
  - Input offered in the flush cycle is dropped. o_ready may be 1 during flush, but nothing is stored.
  - A pop in the flush cycle is still considered consumed by downstream.
- Reset:
  - i_rst overrides i_flush and all handshakes.
  - After reset: count=0, o_valid=0, o_ready=1, o_imm=0, o_pc=0, o_rd/o_rs1/o_rs2=0, o_illegal=0, o_instr_type=R.
  - Reset asserted mid-transfer loses buffered entries with no partial outputs.
- Payload registers need no reset for area. When o_valid=0 the outputs must still read their last-reset or last-popped values, never X.

Test Plan:
- Reset then push 0xFFF00093 (addi x1,x0,-1) with i_ready=1 → next cycle: o_valid=1, type=I, o_imm=0xFFFFFFFF, o_rd=1.
- Push 0xFE112E23 (sw x1,-4(x2)) → type=S, o_imm=0xFFFFFFFC, o_rs1=2, o_rs2=1.
- Push 0xFE000CE3 (beq -8) → type=B, o_imm=0xFFFFFFF8. Push 0x123450B7 (lui) → type=U, o_imm=0x12345000. Push 0x0010006F (jal +2048) → type=J, o_imm=0x00000800.
- Hold i_ready=0 and push 3 entries:
  - The first two are accepted and o_ready drops after the second.
  - Head stays stable.
  - Release i_ready → entries pop in order and o_ready returns to 1.
- With count=1, push and pop in the same cycle → count stays 1 and order is preserved. Push 0x0000007F → o_illegal=1, o_imm=0.
- With count=2, assert i_flush together with i_valid → next cycle o_valid=0 and count=0; the flushed-cycle input never appears.
- Assert i_rst mid-traffic → next cycle all outputs at their reset values.
